// File: rtl/dma_copy_engine.sv
// Memory-to-memory word copy engine: a register-programmed DMA that reads SRC and writes DST, one word at a time.
// Latency: config access completes 1 cycle after acceptance; each copied word costs (rd lat + 1) + (wr lat + 1) cycles.
// Backpressure: the master port holds its request until m_ready_i; the config port services one request every 2 cycles.
//
// Optional build macro: DMA_FILL_EN enables CTRL.FILL (bit4), a pattern fill mode where SRC is written to every DST word.
//
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   cfg_valid_i / cfg_ready_o    config request / one-cycle completion pulse
//   cfg_addr_i                   config address, bits [3:2] select SRC/DST/LEN/CTRL
//   cfg_wdata_i, cfg_we_i        config write data and byte strobes (any nonzero strobe writes the whole word)
//   cfg_rdata_o                  config read data, valid while cfg_ready_o=1
//   m_valid_o / m_ready_i        master request / completion handshake
//   m_addr_o, m_wdata_o, m_we_o  master request payload, held stable until completion
//   m_rdata_i                    master read data, sampled when m_ready_i=1
//   irq_o                        level interrupt, DONE & IEN
module dma_copy_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [ADDR_WIDTH-1:0] cfg_addr_i,
    input  logic [31:0]           cfg_wdata_i,
    input  logic [3:0]            cfg_we_i,
    output logic [31:0]           cfg_rdata_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic [31:0]           m_wdata_o,
    output logic [3:0]            m_we_o,
    input  logic [31:0]           m_rdata_i,
    output logic                  irq_o
);

`ifdef DMA_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // Programmed registers (never modified by a transfer)
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  ien_q;
    logic                  done_q;
    logic                  fill_q;

    // Config port
    logic                  cfg_ready_q;
    logic [31:0]           cfg_rdata_q;
    logic [31:0]           cfg_rdata_d;

    // Transfer engine
    state_t                state_q;
    logic [ADDR_WIDTH-1:0] src_ptr_q;
    logic [ADDR_WIDTH-1:0] dst_ptr_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [31:0]           buf_q;

    // Master port
    logic                  m_valid_q;
    logic [ADDR_WIDTH-1:0] m_addr_q;
    logic [31:0]           m_wdata_q;
    logic [3:0]            m_we_q;

    logic       cfg_accept;
    logic       cfg_wr;
    logic       cfg_rd;
    logic [1:0] cfg_sel;
    logic       busy;
    logic       start_req;
    logic       done_clr;
    logic       fill_wr;
    logic [31:0] src_rd;
    logic       unused_cfg_addr;

    // A request is taken only while no response is pending, which gives the 2-cycle service rate.
    assign cfg_accept = cfg_valid_i & ~cfg_ready_q;
    assign cfg_wr     = cfg_accept & (|cfg_we_i);
    assign cfg_rd     = cfg_accept & ~(|cfg_we_i);
    assign cfg_sel    = cfg_addr_i[3:2];
    assign busy       = (state_q != S_IDLE);

    assign start_req  = cfg_wr && (cfg_sel == 2'd3) && cfg_wdata_i[0] && !busy;
    assign done_clr   = cfg_wr && (cfg_sel == 2'd3) && cfg_wdata_i[2];
    // FILL is usually written together with START, so the launching decision uses the incoming bit.
    assign fill_wr    = FILL_EN & cfg_wdata_i[4];

    // Without fill support SRC is purely an address, so its byte offset reads back as zero.
    assign src_rd = FILL_EN ? 32'(src_q) : 32'({src_q[ADDR_WIDTH-1:2], 2'b00});

    assign unused_cfg_addr = ^{cfg_addr_i[ADDR_WIDTH-1:4], cfg_addr_i[1:0]};

    always_comb begin
        cfg_rdata_d = '0;
        case (cfg_sel)
            2'd0:    cfg_rdata_d = src_rd;
            2'd1:    cfg_rdata_d = 32'(dst_q);
            2'd2:    cfg_rdata_d = 32'(len_q);
            default: cfg_rdata_d = {27'd0, fill_q, ien_q, done_q, busy, 1'b0};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            ien_q       <= 1'b0;
            done_q      <= 1'b0;
            fill_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
            cfg_rdata_q <= '0;
            state_q     <= S_IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            cnt_q       <= '0;
            buf_q       <= '0;
            m_valid_q   <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_we_q      <= 4'h0;
        end else begin
            cfg_ready_q <= cfg_accept;
            cfg_rdata_q <= cfg_rd ? cfg_rdata_d : 32'd0;

            // Programming writes; transfer parameters are locked while busy, IEN is not.
            if (cfg_wr) begin
                case (cfg_sel)
                    2'd0: if (!busy) src_q <= cfg_wdata_i[ADDR_WIDTH-1:0];
                    2'd1: if (!busy) dst_q <= {cfg_wdata_i[ADDR_WIDTH-1:2], 2'b00};
                    2'd2: if (!busy) len_q <= cfg_wdata_i[LEN_WIDTH-1:0];
                    default: begin
                        ien_q <= cfg_wdata_i[3];
                        // Mode is part of the transfer setup, so it shares the busy lockout.
                        if (!busy) fill_q <= fill_wr;
                    end
                endcase
            end

            // Clear first; the FIN assignment below comes later and therefore wins.
            if (done_clr) done_q <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (start_req) begin
                        src_ptr_q <= {src_q[ADDR_WIDTH-1:2], 2'b00};
                        dst_ptr_q <= dst_q;
                        cnt_q     <= len_q;
                        done_q    <= 1'b0;
                        if (len_q == '0)  state_q <= S_FIN;
                        else if (fill_wr) state_q <= S_WR;
                        else              state_q <= S_RD;
                    end
                end
                S_RD: begin
                    // The cycle spent in the state before raising valid is the mandatory gap
                    // between completion of one request and issue of the next.
                    if (!m_valid_q) begin
                        m_valid_q <= 1'b1;
                        m_addr_q  <= src_ptr_q;
                        m_we_q    <= 4'h0;
                    end else if (m_ready_i) begin
                        m_valid_q <= 1'b0;
                        buf_q     <= m_rdata_i;
                        state_q   <= S_WR;
                    end
                end
                S_WR: begin
                    if (!m_valid_q) begin
                        m_valid_q <= 1'b1;
                        m_addr_q  <= dst_ptr_q;
                        m_wdata_q <= fill_q ? 32'(src_q) : buf_q;
                        m_we_q    <= 4'hF;
                    end else if (m_ready_i) begin
                        m_valid_q <= 1'b0;
                        m_we_q    <= 4'h0;
                        src_ptr_q <= src_ptr_q + ADDR_WIDTH'(4);
                        dst_ptr_q <= dst_ptr_q + ADDR_WIDTH'(4);
                        cnt_q     <= cnt_q - LEN_WIDTH'(1);
                        if (cnt_q == LEN_WIDTH'(1)) state_q <= S_FIN;
                        else if (fill_q)            state_q <= S_WR;
                        else                        state_q <= S_RD;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready_o = cfg_ready_q;
    assign cfg_rdata_o = cfg_rdata_q;
    assign m_valid_o   = m_valid_q;
    assign m_addr_o    = m_addr_q;
    assign m_wdata_o   = m_wdata_q;
    assign m_we_o      = m_we_q;
    assign irq_o       = done_q & ien_q;

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- Memory-to-memory word copy engine and the second bus initiator in the SoC.
- The core configures it through a slave register port attached to a spare dmem arbiter master port.
- It masters its own valid/ready port to reach the data RAM and peripherals.
- Completion is reported through a status bit and a level interrupt.

Parameters:
- ADDR_WIDTH, 32, master/config address width.
- LEN_WIDTH, 16, width of the word-count register; maximum transfer is 2^LEN_WIDTH-1 words.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- cfg_valid_i  input  1  config request valid.
- cfg_ready_o  output  1  config request complete, one-cycle pulse.
- cfg_addr_i  input  ADDR_WIDTH  config address; only bits [3:2] are decoded.
- cfg_wdata_i  input  32  config write data.
- cfg_we_i  input  4  byte write strobes; 0 means read; any nonzero value writes the full word.
- cfg_rdata_o  output  32  config read data, valid while cfg_ready_o=1.
- m_valid_o  output  1  master request valid.
- m_ready_i  input  1  master request complete.
- m_addr_o  output  ADDR_WIDTH  master address, word aligned.
- m_wdata_o  output  32  master write data.
- m_we_o  output  4  master strobes: 4'hF for writes, 4'h0 for reads.
- m_rdata_i  input  32  master read data, sampled when m_ready_i=1.
- irq_o  output  1  level interrupt equal to DONE & IEN.

Behaviour:
- Reset:
  - All outputs 0.
  - SRC=0, DST=0, LEN=0, IEN=0, DONE=0, state IDLE.
  - Reset mid-transfer drops m_valid_o immediately (asynchronous); no further request is issued.
- Config port:
  - A request is accepted when cfg_valid_i=1 and cfg_ready_o=0.
  - cfg_ready_o pulses high exactly one cycle later; read data is registered in that same cycle.
  - Back-to-back requests are serviced every 2 cycles.
- Register map (offset = addr[3:2]):
  - 0 SRC: [1:0] read as 0.
  - 1 DST: [1:0] read as 0.
  - 2 LEN: word count, upper bits read 0.
  - 3 CTRL/STATUS:
    - bit0 START: write 1 to start, reads 0.
    - bit1 BUSY: read-only.
    - bit2 DONE: write 1 to clear.
    - bit3 IEN: read/write.
- Busy lockout: while BUSY, writes to SRC/DST/LEN and START are ignored. IEN and the DONE clear still take effect.
- Master protocol:
  - m_valid_o, m_addr_o, m_wdata_o and m_we_o are held stable from assertion until the cycle in which m_ready_i=1.
  - m_valid_o drops in the following cycle.
  - A new request is issued no earlier than one cycle after the previous one completes.
- FSM:
  - IDLE: on an accepted START write:
    - Copy SRC, DST and LEN into working counters.
    - Set BUSY and clear DONE.
    - Go to RD, or to FIN if LEN=0.
  - RD: issue a read at the source pointer. On m_ready_i:
    - Latch m_rdata_i into the data buffer.
    - Go to WR.
  - WR: issue a write of the buffer to the destination pointer. On m_ready_i:
    - Add 4 to both pointers, wrapping modulo 2^ADDR_WIDTH.
    - Decrement the remaining count.
    - Go to RD if the count is nonzero, otherwise FIN.
  - FIN (one cycle): BUSY=0, DONE=1, go to IDLE.
- Throughput: each word costs (read latency + 1) + (write latency + 1) cycles. With 1-cycle slaves, N words take 4N+2 cycles from the START acceptance to DONE=1.
- Register readback: the programmed SRC/DST/LEN registers are not modified by a transfer; the working counters are internal.
- Simultaneous events: a DONE-clear write in the same cycle FIN sets DONE leaves DONE=1 (set wins).

Optional Feature:
- DMA_FILL_EN defined:
  - CTRL bit4 FILL becomes read/write.
  - With FILL=1, RD is skipped: every WR writes the SRC register value (the full 32 bits, [1:0] included) as the pattern, and only DST advances.
  - With 1-cycle slaves, N words take 2N+2 cycles.
- DMA_FILL_EN undefined: bit4 reads 0 and writes are ignored; SRC[1:0] read as 0.

Test Plan:
- Config readback: write SRC=0x1003, DST=0x2000, LEN=3, IEN=1 -> reads return 0x1000, 0x2000, 3, CTRL=0x8; each cfg_ready_o arrives 1 cycle after valid.
- Copy 3 words with a 1-cycle responder model (RAM pre-loaded at 0x1000=A,B,C):
  - Master sequence is R 0x1000, W 0x2000=A, R 0x1004, W 0x2004=B, R 0x1008, W 0x2008=C.
  - DONE=1 and irq_o=1 exactly 14 cycles after START.
  - Write 0x4 to CTRL -> irq_o=0.
- LEN=0 start -> no m_valid_o; DONE=1 after 2 cycles.
- Stall and lockout: m_ready_i delayed 5 cycles per beat, DST rewritten mid-transfer -> address/data/we stable during each stall; DST readback unchanged; copy still targets the original DST.
- Wrap and reset: SRC=0xFFFFFFFC, DST=0x0, LEN=2:
  - Second read targets 0x00000000.
  - Assert rst_n=0 during the second WR -> m_valid_o=0 immediately; all registers read 0 after release.
- Fill (DMA_FILL_EN): SRC=0xDEADBEEF, DST=0x3000, LEN=4, FILL=1 -> four writes of 0xDEADBEEF to 0x3000..0x300C, no reads; DONE after 10 cycles.
